// File: rtl/usb_fifo_pkg.sv
// Shared definitions for the USB FIFO write sequencer: state encoding,
// default timing and the phase-length sanity helpers.
package usb_fifo_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_TXE = 3'd1,
      SETUP    = 3'd2,
      STROBE   = 3'd3,
      HOLD     = 3'd4
   } state_e;

   localparam int unsigned DEF_SETUP_CYCLES   = 2;
   localparam int unsigned DEF_PULSE_CYCLES   = 4;
   localparam int unsigned DEF_HOLD_CYCLES    = 2;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 50000;
   localparam int          DEF_CNT_W          = 16;

   // A timed phase must last at least one clock.
   function automatic bit phase_ok(input int unsigned cycles);
      return cycles >= 1;
   endfunction

   // Down-counter load for a phase of the given length; an illegal
   // zero-length phase is clamped to one clock rather than underflowing.
   function automatic int unsigned phase_load(input int unsigned cycles);
      return phase_ok(cycles) ? cycles - 1 : 0;
   endfunction

endpackage

// File: rtl/usb_fifo_wr_seq_sync2.sv
// Two-flop synchronizer for asynchronous USB chip status pins (TXE#, RXF#).
module sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   // Two-stage shift; both stages reset to the pin's inactive level.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/usb_fifo_wr_seq.sv
// Turns each rising edge of the write-request PIO into one timed byte
// write to an FT245-style USB FIFO, with pollable status flags.
//
// state    | meaning
// ---------+---------------------------------------------------------
// IDLE     | no write in progress, bus released
// WAIT_TXE | byte latched, waiting for TXE# low (optionally timed out)
// SETUP    | data driven, strobe low
// STROBE   | data driven, WR strobe high
// HOLD     | data driven after strobe, then done and count++
module usb_fifo_wr_seq
   import usb_fifo_pkg::*;
#(
   parameter int unsigned SETUP_CYCLES   = DEF_SETUP_CYCLES,
   parameter int unsigned PULSE_CYCLES   = DEF_PULSE_CYCLES,
   parameter int unsigned HOLD_CYCLES    = DEF_HOLD_CYCLES,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int          CNT_W          = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             wr_req,
   input  logic [7:0]       wr_data,
   input  logic             clr,
   input  logic             usb_txe_n,
   output logic             usb_wr,
   output logic [7:0]       usb_data,
   output logic             usb_data_oe,
   output logic             busy,
   output logic             done,
   output logic             timeout,
   output logic             overrun,
   output logic [CNT_W-1:0] byte_count
);

   localparam logic [CNT_W-1:0] SETUP_LD   = CNT_W'(phase_load(SETUP_CYCLES));
   localparam logic [CNT_W-1:0] PULSE_LD   = CNT_W'(phase_load(PULSE_CYCLES));
   localparam logic [CNT_W-1:0] HOLD_LD    = CNT_W'(phase_load(HOLD_CYCLES));
   localparam logic [CNT_W-1:0] TIMEOUT_LD = CNT_W'(phase_load(TIMEOUT_CYCLES));
   localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [7:0]       data_q, data_d;
   logic             wr_req_q;
   logic             done_q, done_d;
   logic             timeout_q, timeout_d;
   logic             overrun_q, overrun_d;
   logic [CNT_W-1:0] byte_count_q, byte_count_d;
   logic             usb_wr_q, usb_wr_d;
   logic             oe_q, oe_d;
   logic             busy_q, busy_d;
   logic [7:0]       usb_data_q, usb_data_d;
   logic             txe_s;
   logic             req_edge;

   sync2 #(.RESET_VAL(1'b1)) u_txe_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (usb_txe_n),
      .q       (txe_s)
   );

   assign req_edge = wr_req & ~wr_req_q;

   // State, datapath and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         data_q       <= '0;
         wr_req_q     <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         overrun_q    <= 1'b0;
         byte_count_q <= '0;
         usb_wr_q     <= 1'b0;
         oe_q         <= 1'b0;
         busy_q       <= 1'b0;
         usb_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         data_q       <= data_d;
         wr_req_q     <= wr_req;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
         overrun_q    <= overrun_d;
         byte_count_q <= byte_count_d;
         usb_wr_q     <= usb_wr_d;
         oe_q         <= oe_d;
         busy_q       <= busy_d;
         usb_data_q   <= usb_data_d;
      end
   end

   // Next state, phase timer and sticky flags; a flag set beats clr.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      data_d       = data_q;
      done_d       = done_q;
      timeout_d    = timeout_q;
      overrun_d    = overrun_q;
      byte_count_d = byte_count_q;

      if (clr) begin
         done_d    = 1'b0;
         timeout_d = 1'b0;
         overrun_d = 1'b0;
      end
      if (req_edge && (state_q != IDLE)) overrun_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (req_edge) begin
               data_d    = wr_data;
               done_d    = 1'b0;
               timeout_d = 1'b0;
               cnt_d     = TIMEOUT_LD;
               state_d   = WAIT_TXE;
            end
         end
         WAIT_TXE: begin
            if (!txe_s) begin
               cnt_d   = SETUP_LD;
               state_d = SETUP;
            end else if (TIMEOUT_EN && (cnt_q == '0)) begin
               timeout_d = 1'b1;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               cnt_d   = PULSE_LD;
               state_d = STROBE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         STROBE: begin
            if (cnt_q == '0) begin
               cnt_d   = HOLD_LD;
               state_d = HOLD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         HOLD: begin
            if (cnt_q == '0) begin
               done_d       = 1'b1;
               byte_count_d = byte_count_q + 1'b1;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output decode from the next state so the outputs are registered
   // yet line up with the state they belong to.
   always_comb begin
      usb_wr_d   = (state_d == STROBE);
      oe_d       = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
      busy_d     = (state_d != IDLE);
      usb_data_d = oe_d ? data_d : usb_data_q;
   end

   assign usb_wr      = usb_wr_q;
   assign usb_data    = usb_data_q;
   assign usb_data_oe = oe_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign timeout     = timeout_q;
   assign overrun     = overrun_q;
   assign byte_count  = byte_count_q;

endmodule
